pipe_alu_stage: RTL and testbench

- Parametrised, multi-stage pipelined ALU for the next-generation pipelined processor core; replaces the fixed-width, single-cycle ALU feeding ALU_output.
- Accepts one operation per cycle under a valid/ready handshake and returns the result and flags after a configurable number of register stages.
- Carries a user tag so the core can match results to writeback destinations.
- Supports global stall (backpressure) and flush (branch mispredict squash).

---
 rtl/pipe_alu_stage.sv | 122 ++++++++++++
 tb/tb_pipe_alu_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_stage.sv
// pipe_alu_stage: pipelined ALU with valid/ready, stall, flush and tag pass-through.
// Optional multiplier (opcode 10) enabled by defining PIPE_ALU_MUL_EN.
module pipe_alu_stage #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf
);
  localparam int SH = $clog2(WIDTH);
  logic             v   [1:STAGES];
  logic [WIDTH-1:0] res [1:STAGES];
  logic [TAG_W-1:0] tag [1:STAGES];
  logic             z   [1:STAGES];
  logic             c   [1:STAGES];
  logic             o   [1:STAGES];
  logic             adv, legal, zr, cr, orr, z2;
  logic [WIDTH:0]   sum, dif;
  logic [SH-1:0]    sa;
  logic [WIDTH-1:0] r, r2;
  assign sa = in_b[SH-1:0];
  assign sum = {1'b0, in_a} + {1'b0, in_b};
  assign dif = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
  assign adv = !v[STAGES] || out_ready;
  assign in_ready = adv;
`ifdef PIPE_ALU_MUL_EN
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] m_hi;
  logic             m1;
  // stage 1 holds a*b_lo in res[1] and a*b_hi in m_hi; the sum completes on entry to stage 2
  assign r2 = m1 ? res[1] + (m_hi << H) : res[1];
  assign z2 = m1 ? r2 == '0 : z[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      m_hi <= '0;
      m1 <= 1'b0;
    end else if (adv) begin
      m_hi <= in_a * WIDTH'(in_b[WIDTH-1:H]);
      m1 <= (in_op == 4'd10) && (STAGES > 1);
    end
  end
`else
  assign r2 = res[1];
  assign z2 = z[1];
`endif
  always_comb begin
    r = '0;
    legal = 1'b1;
    case (in_op)
      4'd0: r = sum[WIDTH-1:0];
      4'd1: r = dif[WIDTH-1:0];
      4'd2: r = in_a & in_b;
      4'd3: r = in_a | in_b;
      4'd4: r = in_a ^ in_b;
      4'd5: r = WIDTH'($signed(in_a) < $signed(in_b));
      4'd6: r = WIDTH'(in_a < in_b);
      4'd7: r = in_a << sa;
      4'd8: r = in_a >> sa;
      4'd9: r = $unsigned($signed(in_a) >>> sa);
`ifdef PIPE_ALU_MUL_EN
      4'd10: r = (STAGES == 1) ? in_a * in_b : in_a * WIDTH'(in_b[H-1:0]);
`endif
      default: legal = 1'b0;
    endcase
  end
  assign zr = legal && r == '0;
  assign cr = in_op == 4'd0 ? sum[WIDTH] : in_op == 4'd1 ? dif[WIDTH] : 1'b0;
  assign orr = in_op == 4'd0 ? (in_a[WIDTH-1] == in_b[WIDTH-1] && sum[WIDTH-1] != in_a[WIDTH-1]) :
               in_op == 4'd1 ? (in_a[WIDTH-1] != in_b[WIDTH-1] && dif[WIDTH-1] != in_a[WIDTH-1]) : 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= STAGES; i++) begin
        v[i] <= 1'b0;
        res[i] <= '0;
        tag[i] <= '0;
        z[i] <= 1'b0;
        c[i] <= 1'b0;
        o[i] <= 1'b0;
      end
    end else begin
      if (adv) begin
        v[1] <= in_valid;
        res[1] <= r;
        tag[1] <= in_tag;
        z[1] <= zr;
        c[1] <= cr;
        o[1] <= orr;
        for (int i = 2; i <= STAGES; i++) begin
          v[i] <= v[i-1];
          res[i] <= (i == 2) ? r2 : res[i-1];
          tag[i] <= tag[i-1];
          z[i] <= (i == 2) ? z2 : z[i-1];
          c[i] <= c[i-1];
          o[i] <= o[i-1];
        end
      end
      if (flush)
        for (int i = 1; i <= STAGES; i++) v[i] <= 1'b0;
    end
  end
  assign out_valid = v[STAGES];
  assign out_result = res[STAGES];
  assign out_tag = tag[STAGES];
  assign out_zero = z[STAGES];
  assign out_carry = c[STAGES];
  assign out_ovf = o[STAGES];
endmodule

// File: tb/tb_pipe_alu_stage.sv
// tb_pipe_alu_stage: directed checks of pipe_alu_stage at STAGES=2, plus STAGES=1/4 reset checks.
module tb_pipe_alu_stage;
  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [3:0] in_op;
  logic [31:0] in_a, in_b;
  logic [4:0] in_tag;
  logic in_ready, out_valid, out_zero, out_carry, out_ovf;
  logic [31:0] out_result;
  logic [4:0] out_tag;
  logic rdy1, val1, z1, c1, o1, rdy4, val4, z4, c4, o4;
  logic [31:0] res1, res4;
  logic [4:0] tag1, tag4;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_alu_stage #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero),
    .out_carry(out_carry), .out_ovf(out_ovf));
  pipe_alu_stage #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(val1),
    .out_ready(out_ready), .out_result(res1), .out_tag(tag1), .out_zero(z1),
    .out_carry(c1), .out_ovf(o1));
  pipe_alu_stage #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(val4),
    .out_ready(out_ready), .out_result(res4), .out_tag(tag4), .out_zero(z4),
    .out_carry(c4), .out_ovf(o4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = t;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    vectors++;
    if (out_result !== 32'd0) begin miscompares++; $display("FAIL reset out_result got %h want 0", out_result); end
    vectors++;
    if (out_tag !== 5'd0) begin miscompares++; $display("FAIL reset out_tag got %0d want 0", out_tag); end
    vectors++;
    if ({out_zero, out_carry, out_ovf} !== 3'b000) begin miscompares++; $display("FAIL reset flags got %b want 000", {out_zero, out_carry, out_ovf}); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3);
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b early out_valid got %b want 0", out_valid); end
    drive(4'd1, 32'd5, 32'd5, 5'd4);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd3) begin miscompares++; $display("FAIL b2b add valid/tag got %b/%0d want 1/3", out_valid, out_tag); end
    vectors++;
    if (out_result !== 32'h8000_0000) begin miscompares++; $display("FAIL b2b add result got %h want 80000000", out_result); end
    vectors++;
    if ({out_zero, out_carry, out_ovf} !== 3'b001) begin miscompares++; $display("FAIL b2b add flags zco got %b want 001", {out_zero, out_carry, out_ovf}); end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd4) begin miscompares++; $display("FAIL b2b sub valid/tag got %b/%0d want 1/4", out_valid, out_tag); end
    vectors++;
    if (out_result !== 32'd0) begin miscompares++; $display("FAIL b2b sub result got %h want 0", out_result); end
    vectors++;
    if ({out_zero, out_carry, out_ovf} !== 3'b110) begin miscompares++; $display("FAIL b2b sub flags zco got %b want 110", {out_zero, out_carry, out_ovf}); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_logic_shift();
    logic [3:0] ops [10] = '{4'd2, 4'd3, 4'd4, 4'd9, 4'd8, 4'd5, 4'd6, 4'd7, 4'd10, 4'd15};
    logic [31:0] va [10] = '{32'hF0F0_FFFF, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] vb [10] = '{32'h0FF0_F00F, 32'h0000_000F, 32'h0F0F_0F0F, 32'd4, 32'd4,
                             32'd1, 32'd1, 32'd33, 32'd7, 32'hFFFF_FFFF};
`ifdef PIPE_ALU_MUL_EN
    logic [31:0] e10 = 32'd35;
`else
    logic [31:0] e10 = 32'd0;
`endif
    logic [31:0] er [10] = '{32'h00F0_F00F, 32'hF000_000F, 32'hF0F0_0F0F, 32'hFF00_0000, 32'h0F00_0000,
                             32'd1, 32'd0, 32'd2, e10, 32'd0};
    logic ez [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(ops[i], va[i], vb[i], 5'(i + 10));
      else in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 5'(i + 9)) begin miscompares++; $display("FAIL op%0d valid/tag got %b/%0d want 1/%0d", ops[i-1], out_valid, out_tag, i + 9); end
        vectors++;
        if (out_result !== er[i-1]) begin miscompares++; $display("FAIL op%0d result got %h want %h", ops[i-1], out_result, er[i-1]); end
        vectors++;
        if ({out_zero, out_carry, out_ovf} !== {ez[i-1], 2'b00}) begin miscompares++; $display("FAIL op%0d flags zco got %b want %b00", ops[i-1], {out_zero, out_carry, out_ovf}, ez[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(4'd0, 32'd1, 32'd2, 5'd1);
    tick();
    drive(4'd1, 32'd10, 32'd3, 5'd2);
    tick();
    out_ready = 1'b0;
    drive(4'd4, 32'hFF, 32'h0F, 5'd3);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_result !== 32'd3) begin
        miscompares++;
        $display("FAIL stall hold%0d valid/tag/result got %b/%0d/%h want 1/1/3", i, out_valid, out_tag, out_result);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_result !== 32'd7) begin miscompares++; $display("FAIL drain B valid/tag/result got %b/%0d/%h want 1/2/7", out_valid, out_tag, out_result); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_result !== 32'hF0) begin miscompares++; $display("FAIL drain C valid/tag/result got %b/%0d/%h want 1/3/f0", out_valid, out_tag, out_result); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain end out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(4'd0, 32'd1, 32'd1, 5'd5);
    tick();
    drive(4'd0, 32'd2, 32'd2, 5'd6);
    tick();
    flush = 1'b1;
    drive(4'd0, 32'd3, 32'd3, 5'd7);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush in_ready got %b want 1", in_ready); end
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush cycle1 out_valid got %b want 0", out_valid); end
    drive(4'd0, 32'd100, 32'd23, 5'd8);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush cycle2 out_valid got %b want 0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd8 || out_result !== 32'd123) begin miscompares++; $display("FAIL post-flush valid/tag/result got %b/%0d/%0d want 1/8/123", out_valid, out_tag, out_result); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(4'd0, 32'(i), 32'(i), 5'(i));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    vectors++;
    if ({rdy1, in_ready, rdy4} !== 3'b000) begin miscompares++; $display("FAIL full in_ready s1/s2/s4 got %b want 000", {rdy1, in_ready, rdy4}); end
    vectors++;
    if (res1 !== 32'd8 || tag1 !== 5'd4) begin miscompares++; $display("FAIL s1 full result/tag got %0d/%0d want 8/4", res1, tag1); end
    vectors++;
    if (out_result !== 32'd6 || out_tag !== 5'd3) begin miscompares++; $display("FAIL s2 full result/tag got %0d/%0d want 6/3", out_result, out_tag); end
    vectors++;
    if (val4 !== 1'b1 || res4 !== 32'd2 || tag4 !== 5'd1) begin miscompares++; $display("FAIL s4 full valid/result/tag got %b/%0d/%0d want 1/2/1", val4, res4, tag4); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({val1, out_valid, val4} !== 3'b000) begin miscompares++; $display("FAIL mid-reset out_valid s1/s2/s4 got %b want 000", {val1, out_valid, val4}); end
    vectors++;
    if (res1 !== 32'd0 || out_result !== 32'd0 || res4 !== 32'd0) begin miscompares++; $display("FAIL mid-reset result s1/s2/s4 got %h/%h/%h want 0", res1, out_result, res4); end
    vectors++;
    if ({rdy1, in_ready, rdy4} !== 3'b111) begin miscompares++; $display("FAIL mid-reset in_ready s1/s2/s4 got %b want 111", {rdy1, in_ready, rdy4}); end
    out_ready = 1'b1;
  endtask

`ifdef PIPE_ALU_MUL_EN
  task automatic test_mul();
    out_ready = 1'b1;
    drive(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd20);
    tick();
    drive(4'd10, 32'd1234, 32'd5678, 5'd21);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd20 || out_result !== 32'd0 || {out_zero, out_carry, out_ovf} !== 3'b100) begin
      miscompares++;
      $display("FAIL mul wrap valid/tag/result/zco got %b/%0d/%h/%b want 1/20/0/100", out_valid, out_tag, out_result, {out_zero, out_carry, out_ovf});
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 5'd21 || out_result !== 32'd7006652 || out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL mul valid/tag/result/zero got %b/%0d/%0d/%b want 1/21/7006652/0", out_valid, out_tag, out_result, out_zero);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_logic_shift();
    test_stall();
    test_flush();
`ifdef PIPE_ALU_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
